mask_pool_reader: RTL and testbench

// - Reads the binary foreground mask produced by the green-screen filter (1 = non-green, 0 = green).
// - Consumes the mask as a one-pixel-per-beat valid/ready stream in raster order.
// - Sums each POOLxPOOL tile into a count and streams the 20x30 count map to the neural-net input stage.
// - Pipeline position: mask-producer side -> this block -> NN feature loader.

---
 rtl/nn_img_pkg.sv | 17 +
 rtl/pool_row_accum.sv | 45 ++++
 rtl/mask_pool_reader.sv | 167 ++++++++++++++++
 tb/tb_mask_pool_reader.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nn_img_pkg.sv
// Shared image/pooling constants and types for the mask-to-NN feature path.
// The frame geometry defaults describe the green-screen mask as the NN expects it.
package nn_img_pkg;

    localparam int IMG_H = 200;
    localparam int IMG_W = 300;
    localparam int POOL  = 10;

    typedef logic mask_t;
    typedef logic [$clog2(POOL*POOL+1)-1:0] tile_cnt_t;

    typedef enum logic {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } pool_state_e;

endpackage

// File: rtl/pool_row_accum.sv
// Bank of per-tile-column accumulators covering one band of POOL mask rows.
// snap shows every count including the bit being added this cycle, so a snapshot and a clear can share an edge.
module pool_row_accum #(
    parameter int TX    = 30,
    parameter int CNT_W = 7,
    parameter int IDX_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                add_en,
    input  logic [IDX_W-1:0]    add_idx,
    input  logic                add_bit,
    input  logic                clear,
    output logic [TX*CNT_W-1:0] snap
);
    import nn_img_pkg::*;

    mask_t            add_m;
    logic [CNT_W-1:0] acc_q [TX];
    logic [CNT_W-1:0] acc_d [TX];
    logic [CNT_W-1:0] sum   [TX];

    assign add_m = add_bit;

    always_comb begin
        snap = '0;
        for (int k = 0; k < TX; k++) begin
            sum[k] = acc_q[k];
            if (add_en && add_m && (add_idx == IDX_W'(k))) begin
                sum[k] = acc_q[k] + CNT_W'(1);
            end
            acc_d[k] = clear ? '0 : sum[k];
            snap[k*CNT_W +: CNT_W] = sum[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '{default: '0};
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/mask_pool_reader.sv
// Pools the green-screen foreground mask into POOLxPOOL tile counts and streams them to the NN loader.
// One band of rows is accumulated while the previous band's counts drain from a snapshot buffer.
module mask_pool_reader #(
    parameter int IMG_H = 200,
    parameter int IMG_W = 300,
    parameter int POOL  = 10
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                s_bit,
    input  logic                                s_last,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [$clog2(POOL*POOL+1)-1:0]      m_count,
    output logic [$clog2(IMG_W/POOL)-1:0]       m_tx,
    output logic [$clog2(IMG_H/POOL)-1:0]       m_ty,
    output logic                                m_last,
    output logic                                frame_err
);
    import nn_img_pkg::*;

    localparam int CNT_W = $clog2(POOL*POOL+1);
    localparam int TX    = IMG_W / POOL;
    localparam int TY    = IMG_H / POOL;
    localparam int TXW   = $clog2(TX);
    localparam int TYW   = $clog2(TY);
    localparam int PSW   = $clog2(POOL);

    pool_state_e      state_q, state_d;
    logic [PSW-1:0]   col_sub_q, col_sub_d;
    logic [TXW-1:0]   tile_col_q, tile_col_d;
    logic [PSW-1:0]   row_sub_q, row_sub_d;
    logic [TYW-1:0]   tile_row_q, tile_row_d;
    logic [TXW-1:0]   beat_q, beat_d;
    logic [TYW-1:0]   oty_q, oty_d;
    logic [CNT_W-1:0] obuf_q [TX];
    logic [CNT_W-1:0] obuf_d [TX];
    logic             frame_err_q, frame_err_d;

    mask_t               pix_bit;
    logic [TX*CNT_W-1:0] snap;
    logic                at_col_end;
    logic                at_group_end;
    logic                at_frame_end;
    logic                drain_done;
    logic                accept;
    logic                early_last;
    logic                group_end;

    assign pix_bit = s_bit;

    pool_row_accum #(
        .TX    (TX),
        .CNT_W (CNT_W),
        .IDX_W (TXW)
    ) u_accum (
        .clk     (clk),
        .rst_n   (rst_n),
        .add_en  (accept),
        .add_idx (tile_col_q),
        .add_bit (pix_bit),
        .clear   (group_end || early_last),
        .snap    (snap)
    );

    // Handshake qualification: the band-closing pixel waits only if the old band is still draining.
    always_comb begin
        at_col_end   = (col_sub_q == PSW'(POOL-1)) && (tile_col_q == TXW'(TX-1));
        at_group_end = at_col_end && (row_sub_q == PSW'(POOL-1));
        at_frame_end = at_group_end && (tile_row_q == TYW'(TY-1));
        drain_done   = (state_q == DRAIN) && m_ready && (beat_q == TXW'(TX-1));
        s_ready      = !((state_q == DRAIN) && at_group_end && !drain_done);
        accept       = s_valid && s_ready;
        early_last   = accept && s_last && !at_frame_end;
        group_end    = accept && at_group_end && !early_last;
        frame_err_d  = accept && (s_last != at_frame_end);
    end

    // Raster position, kept as tile index plus offset inside the tile to avoid dividers.
    always_comb begin
        col_sub_d  = col_sub_q;
        tile_col_d = tile_col_q;
        row_sub_d  = row_sub_q;
        tile_row_d = tile_row_q;
        if (early_last) begin
            col_sub_d  = '0;
            tile_col_d = '0;
            row_sub_d  = '0;
            tile_row_d = '0;
        end else if (accept) begin
            if (col_sub_q == PSW'(POOL-1)) begin
                col_sub_d = '0;
                if (tile_col_q == TXW'(TX-1)) begin
                    tile_col_d = '0;
                    if (row_sub_q == PSW'(POOL-1)) begin
                        row_sub_d  = '0;
                        tile_row_d = (tile_row_q == TYW'(TY-1)) ? '0 : tile_row_q + TYW'(1);
                    end else begin
                        row_sub_d = row_sub_q + PSW'(1);
                    end
                end else begin
                    tile_col_d = tile_col_q + TXW'(1);
                end
            end else begin
                col_sub_d = col_sub_q + PSW'(1);
            end
        end
    end

    // Drain FSM; a band close on the final drain beat reloads the buffer and restarts the drain.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        oty_d   = oty_q;
        obuf_d  = obuf_q;
        if (drain_done) begin
            state_d = ACCUM;
            beat_d  = '0;
        end else if ((state_q == DRAIN) && m_ready) begin
            beat_d = beat_q + TXW'(1);
        end
        if (group_end) begin
            state_d = DRAIN;
            beat_d  = '0;
            oty_d   = tile_row_q;
            for (int k = 0; k < TX; k++) begin
                obuf_d[k] = snap[k*CNT_W +: CNT_W];
            end
        end
    end

    always_comb begin
        m_valid   = (state_q == DRAIN);
        m_count   = obuf_q[beat_q];
        m_tx      = beat_q;
        m_ty      = oty_q;
        m_last    = m_valid && (beat_q == TXW'(TX-1)) && (oty_q == TYW'(TY-1));
        frame_err = frame_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            col_sub_q   <= '0;
            tile_col_q  <= '0;
            row_sub_q   <= '0;
            tile_row_q  <= '0;
            beat_q      <= '0;
            oty_q       <= '0;
            obuf_q      <= '{default: '0};
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_sub_q   <= col_sub_d;
            tile_col_q  <= tile_col_d;
            row_sub_q   <= row_sub_d;
            tile_row_q  <= tile_row_d;
            beat_q      <= beat_d;
            oty_q       <= oty_d;
            obuf_q      <= obuf_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_mask_pool_reader.sv
// Self-checking bench for mask_pool_reader on a reduced 16x24 frame pooled in 4x4 tiles.
// Frame-level vectors come from a table; early s_last and mid-drain reset are hand sequences.
module tb_mask_pool_reader;

    localparam int IMG_H   = 16;
    localparam int IMG_W   = 24;
    localparam int POOL    = 4;
    localparam int TX      = IMG_W / POOL;
    localparam int TY      = IMG_H / POOL;
    localparam int CNT_W   = $clog2(POOL*POOL+1);
    localparam int TXW     = $clog2(TX);
    localparam int TYW     = $clog2(TY);
    localparam int NPIX    = IMG_H * IMG_W;
    localparam int NBEAT   = TX * TY;
    localparam int GRP_PIX = POOL * IMG_W;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic             s_bit = 1'b0;
    logic             s_last = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [CNT_W-1:0] m_count;
    logic [TXW-1:0]   m_tx;
    logic [TYW-1:0]   m_ty;
    logic             m_last;
    logic             frame_err;

    always #5 clk = ~clk;

    mask_pool_reader #(
        .IMG_H (IMG_H),
        .IMG_W (IMG_W),
        .POOL  (POOL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_bit     (s_bit),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_count   (m_count),
        .m_tx      (m_tx),
        .m_ty      (m_ty),
        .m_last    (m_last),
        .frame_err (frame_err)
    );

    // uni < 0 means tile counts come from summing pixBit over the tile.
    typedef struct {
        int pat;
        int mrMode;
        bit randValid;
        int uni;
        int spTy;
        int spTx;
        int spCnt;
        int nPix;
        int expBeats;
        int expErr;
        int abortBeat;
    } vec_t;

    int   vecCount  = 0;
    int   missCount = 0;
    vec_t tbl [5];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic bit pixBit(input int pat, input int y, input int x);
        case (pat)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return bit'((x ^ y) & 1);
            3:       return (y == 9) && (x == 14);
            default: return ((x*7 + y*3) % 5) == 0;
        endcase
    endfunction

    function automatic int expCount(input vec_t v, input int ty, input int tx);
        int s = 0;
        if (v.uni >= 0) return (ty == v.spTy && tx == v.spTx) ? v.spCnt : v.uni;
        for (int y = ty*POOL; y < (ty+1)*POOL; y++)
            for (int x = tx*POOL; x < (tx+1)*POOL; x++)
                s += int'(pixBit(v.pat, y, x));
        return s;
    endfunction

    task automatic applyStimulus(input vec_t v, input string tag);
        int idx = 0, beats = 0, errs = 0, cyc = 0, tail = 0, stallCnt = 0, firstStall = -1;
        int ety, etx;
        bit seenValid = 0, hold = 0, pend = 0;
        logic [CNT_W+TXW+TYW+1:0] prevOut = '0;
        while (tail < 30 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (pend || (idx < v.nPix && (!v.randValid || $urandom_range(0, 9) < 6))) begin
                s_valid = 1'b1;
                s_bit   = pixBit(v.pat, idx / IMG_W, idx % IMG_W);
                s_last  = (idx == v.nPix - 1);
            end else begin
                s_valid = 1'b0;
                s_bit   = 1'b0;
                s_last  = 1'b0;
            end
            if (seenValid) stallCnt++;
            m_ready = (v.mrMode == 1) ? !(seenValid && stallCnt <= 400) : 1'b1;
            #1;
            if (m_valid) seenValid = 1;
            if (v.abortBeat >= 0 && beats == v.abortBeat && m_valid) begin
                rst_n = 1'b0;
                #1;
                checkOutput({tag, " abort valid/ready/count"}, {m_valid, s_ready, m_count, m_last},
                            {1'b0, 1'b1, {CNT_W{1'b0}}, 1'b0});
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_bit   = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (hold)
                checkOutput({tag, " hold stable"}, {m_valid, m_count, m_tx, m_ty, m_last}, prevOut);
            hold    = m_valid && !m_ready;
            prevOut = {m_valid, m_count, m_tx, m_ty, m_last};
            if (frame_err) errs++;
            if (s_valid && !s_ready) begin
                checkOutput({tag, " stall position"}, idx % GRP_PIX, GRP_PIX - 1);
                if (firstStall < 0) firstStall = idx;
            end
            if (m_valid && m_ready) begin
                if (beats >= v.expBeats) begin
                    checkOutput({tag, " extra beat"}, beats, v.expBeats);
                end else begin
                    ety = beats / TX;
                    etx = beats % TX;
                    checkOutput($sformatf("%s beat %0d {count,tx,ty,last}", tag, beats),
                                {m_count, m_tx, m_ty, m_last},
                                {CNT_W'(expCount(v, ety, etx)), TXW'(etx), TYW'(ety),
                                 (ety == TY-1 && etx == TX-1)});
                end
                beats++;
            end
            pend = s_valid && !s_ready;
            if (s_valid && s_ready) idx++;
            if (idx >= v.nPix && beats >= v.expBeats) tail++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checkOutput({tag, " beat count"}, beats, v.expBeats);
        checkOutput({tag, " frame_err pulses"}, errs, v.expErr);
        checkOutput({tag, " pixels accepted"}, idx, v.nPix);
        if (v.mrMode == 1) checkOutput({tag, " first stall pixel"}, firstStall, 2*GRP_PIX - 1);
    endtask

    initial begin
        vec_t earlyV, onesV, abortV;
        // pat, mrMode, randValid, uni, spTy, spTx, spCnt, nPix, expBeats, expErr, abortBeat
        tbl[0] = '{0, 0, 1'b0, 16, -1, -1, 0, NPIX, NBEAT, 0, -1};
        tbl[1] = '{1, 0, 1'b0,  0, -1, -1, 0, NPIX, NBEAT, 0, -1};
        tbl[2] = '{2, 0, 1'b0,  8, -1, -1, 0, NPIX, NBEAT, 0, -1};
        tbl[3] = '{3, 0, 1'b0,  0,  2,  3, 1, NPIX, NBEAT, 0, -1};
        tbl[4] = '{4, 1, 1'b1, -1, -1, -1, 0, NPIX, NBEAT, 0, -1};
        earlyV = '{0, 0, 1'b0, 16, -1, -1, 0, 9*IMG_W + 4, 2*TX, 1, -1};
        onesV  = tbl[0];
        abortV = '{0, 0, 1'b0, 16, -1, -1, 0, NPIX, NBEAT, 0, 2*TX};

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset state", {m_valid, s_ready, m_count, m_tx, m_ty, m_last, frame_err},
                    {1'b0, 1'b1, {CNT_W{1'b0}}, {TXW{1'b0}}, {TYW{1'b0}}, 1'b0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        applyStimulus(earlyV, "early_last");
        applyStimulus(onesV, "after_early");
        applyStimulus(abortV, "reset_mid_drain");
        applyStimulus(onesV, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
